// File: rtl/buffer_pkg.sv
// Shared constants and FSM state type for the buffer unloader.
// Optional parity frame bit is enabled by BUFFER_UNLOADER_PARITY_EN.
package buffer_pkg;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WAIT   = 3'd2,
    S_SHIFT  = 3'd3
`ifdef BUFFER_UNLOADER_PARITY_EN
    ,
    S_PARITY = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/occ_counter.sv
// Saturating occupancy counter with a sticky overflow flag.
// Tracks words written into and read out of the upstream buffer.
module occ_counter
  import buffer_pkg::*;
#(
  parameter int DEPTH = buffer_pkg::DEPTH,
  parameter int CNT_W = buffer_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] occupancy,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // Count writes up, reads down; saturate at FULL and latch overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
      overflow  <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (occupancy == FULL)
            overflow <= 1'b1;
          else
            occupancy <= occupancy + 1'b1;
        end
        2'b01: begin
          if (occupancy != '0)
            occupancy <= occupancy - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/buffer_unloader.sv
// Reads words from a registered-output buffer and serialises them MSB first.
// BUFFER_UNLOADER_PARITY_EN appends an even-parity bit to every frame.
module buffer_unloader
  import buffer_pkg::*;
#(
  parameter int DATA_W = buffer_pkg::DATA_W,
  parameter int DEPTH  = buffer_pkg::DEPTH,
  parameter int CNT_W  = buffer_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buf_w,
  output logic              buf_rd,
  input  logic [DATA_W-1:0] buf_data,
  output logic              ser_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic              busy,
  output logic [CNT_W-1:0]  occupancy,
  output logic              overflow
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t            state;
  state_t            nxt;
  logic [DATA_W-1:0] sr;
  logic [IDX_W-1:0]  idx;
  logic              acc;
  logic              last_bit;
  logic              have_word;
`ifdef BUFFER_UNLOADER_PARITY_EN
  logic              par;
`endif

  assign acc       = ser_valid && ser_ready;
  assign last_bit  = (idx == LAST_IDX);
  assign have_word = (occupancy != '0);

  occ_counter #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_occ (
    .clk       (clk),
    .rst       (rst),
    .inc       (buf_w),
    .dec       (buf_rd),
    .occupancy (occupancy),
    .overflow  (overflow)
  );

  // Next-state: fetch, wait for the registered data, then shift out.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (have_word) nxt = S_READ;
      S_READ:  nxt = S_WAIT;
      S_WAIT:  nxt = S_SHIFT;
      S_SHIFT: begin
        if (acc && last_bit) begin
`ifdef BUFFER_UNLOADER_PARITY_EN
          nxt = S_PARITY;
`else
          nxt = have_word ? S_READ : S_IDLE;
`endif
        end
      end
`ifdef BUFFER_UNLOADER_PARITY_EN
      S_PARITY: if (acc) nxt = have_word ? S_READ : S_IDLE;
`endif
      default: nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Capture the word after WAIT, then shift one bit per accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      idx <= '0;
`ifdef BUFFER_UNLOADER_PARITY_EN
      par <= 1'b0;
`endif
    end else if (state == S_WAIT) begin
      sr  <= buf_data;
      idx <= '0;
`ifdef BUFFER_UNLOADER_PARITY_EN
      par <= ^buf_data;
`endif
    end else if (state == S_SHIFT && acc) begin
      sr  <= sr << 1;
      idx <= idx + 1'b1;
    end
  end

  // Outputs decoded from state; stall-stable since state/sr only move on acc.
  always_comb begin
    buf_rd    = 1'b0;
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    ser_last  = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_READ:  buf_rd = 1'b1;
      S_SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = sr[DATA_W-1];
`ifndef BUFFER_UNLOADER_PARITY_EN
        ser_last  = last_bit;
`endif
      end
`ifdef BUFFER_UNLOADER_PARITY_EN
      S_PARITY: begin
        ser_valid = 1'b1;
        ser_data  = par;
        ser_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
